multicycle_control: RTL and testbench

Multicycle sequencer for the RV32I core. It replaces the single-cycle decode path with an FSM that steps one shared ALU and one unified memory port through fetch, decode, execute, memory and writeback. Per state, it drives the datapath mux selects and write enables. It waits on a memory ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_control.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer: steps a shared ALU and a unified memory port
// through fetch/decode/execute/memory/writeback and drives the datapath
// selects and write enables for each state.
module multicycle_control #(
  parameter int unsigned RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [1:0] DataType,
  output logic       illegal,
  output logic       instr_retired
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LINK, LUI, TRAP
  } state_t;

  // A misconfigured reset parameter parks the sequencer in TRAP instead of
  // silently running from an unintended state.
  localparam state_t RESET_STATE = (RESET_STATE_FETCH == 32'd1) ? FETCH : TRAP;

  state_t state;
  state_t next_state;

  // ALU operation from funct3/funct7[5]; sub only exists for R-type.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic f75,
                                            input logic is_r);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = (is_r && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = f75 ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  // State register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == TRAP) illegal <= 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_B:         next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_JALR:      next_state = JALR;
          OP_LUI:       next_state = LUI;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (mem_ready) next_state = FETCH;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JAL:      next_state = ALUWB;
      JALR:     next_state = LINK;
      LINK:     next_state = ALUWB;
      LUI:      next_state = ALUWB;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  // Per-state datapath controls; enables are squashed while rst is high so an
  // abandoned instruction cannot touch memory, PC or the register file.
  always_comb begin
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    ImmSrc        = 3'b000;
    DataType      = 2'b10;
    instr_retired = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
      end
      MEMADR: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        ImmSrc   = (op == OP_SW) ? 3'b001 : 3'b000;
        DataType = funct3[1:0];
      end
      MEMREAD: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        DataType = funct3[1:0];
      end
      MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      MEMWRITE: begin
        mem_req       = 1'b1;
        MemWrite      = 1'b1;
        AdrSrc        = 1'b1;
        DataType      = funct3[1:0];
        instr_retired = mem_ready;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct75, 1'b1);
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, funct75, 1'b0);
      end
      ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 2'b10;
        ALUControl    = ALU_SUB;
        PCWrite       = Zero ^ funct3[0];
        instr_retired = 1'b1;
      end
      JAL: begin
        ImmSrc  = 3'b011;
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected control word
// is queued as the inputs are driven and checked when the outputs settle.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_TRAP
  } st_e;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic [1:0] data_type;
    logic       illegal;
    logic       instr_retired;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct75 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, DataType;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       illegal, instr_retired;

  int   checks = 0;
  int   failures = 0;
  out_t sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct75(funct75),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .DataType(DataType), .illegal(illegal), .instr_retired(instr_retired)
  );

  // Expected control word for a state, from the state table.
  function automatic out_t exp_out(input st_e st, input logic r, input logic rdy,
                                   input logic [3:0] alu, input logic pcw);
    out_t o;
    o = '0;
    o.data_type = 2'b10;
    case (st)
      S_FETCH:    begin o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                        o.ir_write = rdy; o.pc_write = rdy; end
      S_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.imm_src = 3'b010; end
      S_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
                        o.imm_src = (op == OP_SW) ? 3'b001 : 3'b000;
                        o.data_type = funct3[1:0]; end
      S_MEMREAD:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.data_type = funct3[1:0]; end
      S_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; o.instr_retired = 1'b1; end
      S_MEMWRITE: begin o.mem_req = 1'b1; o.mem_write = 1'b1; o.adr_src = 1'b1;
                        o.data_type = funct3[1:0]; o.instr_retired = rdy; end
      S_EXECR:    begin o.alu_src_a = 2'b10; o.alu_control = alu; end
      S_EXECI:    begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_control = alu; end
      S_ALUWB:    begin o.reg_write = 1'b1; o.instr_retired = 1'b1; end
      S_BRANCH:   begin o.alu_src_a = 2'b10; o.alu_control = 4'b0001; o.pc_write = pcw;
                        o.instr_retired = 1'b1; end
      S_JAL:      begin o.imm_src = 3'b011; o.pc_write = 1'b1; o.alu_src_a = 2'b01;
                        o.alu_src_b = 2'b10; end
      S_JALR:     begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.result_src = 2'b10;
                        o.pc_write = 1'b1; end
      S_LINK:     begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
      S_LUI:      begin o.alu_src_a = 2'b11; o.alu_src_b = 2'b01; o.imm_src = 3'b100; end
      S_TRAP:     o.illegal = 1'b1;
      default:    ;
    endcase
    if (r) begin
      o.mem_req = 1'b0; o.mem_write = 1'b0; o.ir_write = 1'b0;
      o.pc_write = 1'b0; o.reg_write = 1'b0; o.instr_retired = 1'b0;
    end
    return o;
  endfunction

  // One cycle: drive inputs at negedge, queue expectation, check once settled.
  task automatic step(input st_e st, input logic r, input logic rdy, input logic z,
                      input logic [3:0] alu, input logic pcw);
    out_t got;
    out_t exp;
    @(negedge clk);
    rst = r;
    mem_ready = rdy;
    Zero = z;
    sb.push_back(exp_out(st, r, rdy, alu, pcw));
    #1;
    got = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, DataType, illegal, instr_retired};
    exp = sb.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL chk%0d %s got=%h exp=%h", checks, st.name(), got, exp);
    end
  endtask

  task automatic go(input st_e st);
    step(st, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f, input logic f7);
    op = o;
    funct3 = f;
    funct75 = f7;
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input logic [3:0] alu);
    instr(o, f, f7);
    go(S_FETCH);
    go(S_DECODE);
    step((o == OP_R) ? S_EXECR : S_EXECI, 1'b0, 1'b1, 1'b0, alu, 1'b0);
    go(S_ALUWB);
  endtask

  task automatic branch(input logic [2:0] f, input logic z, input logic pcw);
    instr(OP_B, f, 1'b0);
    go(S_FETCH);
    go(S_DECODE);
    step(S_BRANCH, 1'b0, 1'b1, z, 4'b0000, pcw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with mem_ready high: FETCH selects, no enables.
    step(S_FETCH, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(S_FETCH, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);

    // ALU instructions and function decode.
    alu_instr(OP_R, 3'b000, 1'b0, 4'b0000);
    alu_instr(OP_R, 3'b000, 1'b1, 4'b0001);
    alu_instr(OP_R, 3'b011, 1'b0, 4'b1001);
    alu_instr(OP_R, 3'b111, 1'b0, 4'b0010);
    alu_instr(OP_I, 3'b000, 1'b1, 4'b0000);
    alu_instr(OP_I, 3'b101, 1'b1, 4'b0111);
    alu_instr(OP_I, 3'b101, 1'b0, 4'b0110);

    // lw with three wait cycles in FETCH and in MEMREAD.
    instr(OP_LW, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) step(S_FETCH, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    go(S_FETCH);
    go(S_DECODE);
    go(S_MEMADR);
    for (int i = 0; i < 3; i++) step(S_MEMREAD, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    go(S_MEMREAD);
    go(S_MEMWB);

    // sb with MemWrite held across waits.
    instr(OP_SW, 3'b000, 1'b0);
    go(S_FETCH);
    go(S_DECODE);
    go(S_MEMADR);
    for (int i = 0; i < 2; i++) step(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    go(S_MEMWRITE);

    // beq / bne, taken and not taken.
    branch(3'b000, 1'b1, 1'b1);
    branch(3'b000, 1'b0, 1'b0);
    branch(3'b001, 1'b1, 1'b0);
    branch(3'b001, 1'b0, 1'b1);

    // Jumps and lui.
    instr(OP_JAL, 3'b000, 1'b0);
    go(S_FETCH); go(S_DECODE); go(S_JAL); go(S_ALUWB);
    instr(OP_JALR, 3'b000, 1'b0);
    go(S_FETCH); go(S_DECODE); go(S_JALR); go(S_LINK); go(S_ALUWB);
    instr(OP_LUI, 3'b000, 1'b0);
    go(S_FETCH); go(S_DECODE); go(S_LUI); go(S_ALUWB);

    // Reset during a stalled sh: enables drop at once, restart in FETCH.
    instr(OP_SW, 3'b001, 1'b0);
    go(S_FETCH); go(S_DECODE); go(S_MEMADR);
    step(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(S_MEMWRITE, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(S_FETCH, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    go(S_FETCH); go(S_DECODE); go(S_MEMADR); go(S_MEMWRITE);

    // Unsupported opcode: sticky TRAP until reset.
    instr(7'b1111111, 3'b000, 1'b0);
    go(S_FETCH);
    go(S_DECODE);
    for (int i = 0; i < 10; i++) step(S_TRAP, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    step(S_TRAP, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(S_FETCH, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
